// File: rtl/rwc_responder_if.sv
// rwc_responder_if: groups the controller handshake and the BRAM port signals of the RWC responder.
// Latency: none, wiring only.
// Backpressure: none. The level handshake on gen_enable/available is carried unchanged.
//
// Port summary (responder view, slave modport):
//   in : gen_enable, cha_data[DATA_WIDTH], cha_addr[32], bram_doutb[DATA_WIDTH]
//   out: available, rsp_write[DATA_WIDTH], rsp_clean[DATA_WIDTH],
//        bram_ena, bram_wea, bram_addra[ADDR_WIDTH], bram_dina[DATA_WIDTH],
//        bram_enb, bram_addrb[ADDR_WIDTH]
// The master modport is the environment: the top-level controller plus the BRAM primitive.
interface rwc_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    // controller side
    logic                  gen_enable;
    logic [DATA_WIDTH-1:0] cha_data;
    logic [31:0]           cha_addr;
    logic                  available;
    logic [DATA_WIDTH-1:0] rsp_write;
    logic [DATA_WIDTH-1:0] rsp_clean;

    // BRAM side
    logic                  bram_ena;
    logic                  bram_wea;
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [DATA_WIDTH-1:0] bram_dina;
    logic                  bram_enb;
    logic [ADDR_WIDTH-1:0] bram_addrb;
    logic [DATA_WIDTH-1:0] bram_doutb;

    modport slave (
        input  gen_enable,
        input  cha_data,
        input  cha_addr,
        output available,
        output rsp_write,
        output rsp_clean,
        output bram_ena,
        output bram_wea,
        output bram_addra,
        output bram_dina,
        output bram_enb,
        output bram_addrb,
        input  bram_doutb
    );

    modport master (
        output gen_enable,
        output cha_data,
        output cha_addr,
        input  available,
        input  rsp_write,
        input  rsp_clean,
        input  bram_ena,
        input  bram_wea,
        input  bram_addra,
        input  bram_dina,
        input  bram_enb,
        input  bram_addrb,
        output bram_doutb
    );
endinterface

// File: rtl/rwc_responder.sv
// rwc_responder: runs one read-write-collision sequence on a true-dual-port BRAM per gen_enable rising edge.
// Latency: available rises 3+SETTLE_CYCLES+2*READ_LATENCY cycles after the start edge (11 with defaults).
// Backpressure: none toward the BRAM. Results are held in DONE until gen_enable drops (level handshake).
//
// Ports:
//   clk_i   - single clock for the FSM and both BRAM ports
//   rst_i   - synchronous reset, active-high. Aborts any run on the same edge.
//   bus_io  - rwc_responder_if.slave: challenge in, responses out, BRAM port A/B drive, port-B read data in
//
// Sequence: PRECLEAR writes ~data to addr, SETTLE idles, COLLIDE writes data on A while reading the
// same addr on B, WAIT_W captures that read, CLEAN_RD re-reads with A idle, and WAIT_C captures it.
// Every output is a flop. Next-state values are decoded from the *next* FSM state, so the BRAM
// strobes are asserted during exactly the cycle the FSM spends in the matching state.
module rwc_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int READ_LATENCY  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rwc_responder_if.slave   bus_io
);

    // One down-counter serves SETTLE, WAIT_W and WAIT_C, so it is sized for the longer delay.
    localparam int CNT_MAX = (SETTLE_CYCLES > READ_LATENCY) ? SETTLE_CYCLES : READ_LATENCY;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD   = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRECLEAR,
        SETTLE,
        COLLIDE,
        WAIT_W,
        CLEAN_RD,
        WAIT_C,
        DONE
    } state_t;

    typedef struct packed {
        logic                  ena;
        logic                  wea;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } porta_t;

    typedef struct packed {
        logic                  enb;
        logic [ADDR_WIDTH-1:0] addr;
    } portb_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  gen_en_q;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_clean_q, rsp_clean_d;
    logic                  available_q, available_d;
    porta_t                porta_q, porta_d;
    portb_t                portb_q, portb_d;
    logic                  start;

    // Address bits above ADDR_WIDTH are ignored by design.
    logic                  addr_hi_unused;
    assign addr_hi_unused = ^bus_io.cha_addr[31:ADDR_WIDTH];

    // A run starts only on a low-to-high transition seen while idle. A level held high
    // through DONE->IDLE cannot retrigger, because gen_en_q is then 1.
    assign start = (state_q == IDLE) && bus_io.gen_enable && !gen_en_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        addr_d      = addr_q;
        rsp_write_d = rsp_write_q;
        rsp_clean_d = rsp_clean_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PRECLEAR;
                    data_d      = bus_io.cha_data;
                    addr_d      = bus_io.cha_addr[ADDR_WIDTH-1:0];
                    rsp_write_d = '0;
                    rsp_clean_d = '0;
                end
            end
            PRECLEAR: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = COLLIDE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COLLIDE: begin
                state_d = WAIT_W;
                cnt_d   = READ_LOAD;
            end
            WAIT_W: begin
                // The collision read emerges on doutb during the last wait cycle.
                if (cnt_q == '0) begin
                    rsp_write_d = bus_io.bram_doutb;
                    state_d     = CLEAN_RD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CLEAN_RD: begin
                state_d = WAIT_C;
                cnt_d   = READ_LOAD;
            end
            WAIT_C: begin
                if (cnt_q == '0) begin
                    rsp_clean_d = bus_io.bram_doutb;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!bus_io.gen_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // BRAM strobes and the handshake are decoded from state_d and then registered. Port A and
    // port B in COLLIDE therefore come from the same flop edge, with no skew between the enables.
    always_comb begin
        porta_d     = porta_q;
        portb_d     = portb_q;
        porta_d.ena = 1'b0;
        porta_d.wea = 1'b0;
        portb_d.enb = 1'b0;
        available_d = (state_d == DONE);

        case (state_d)
            PRECLEAR: begin
                // Use the freshly latched values. The _q copies are not loaded until this edge.
                porta_d.ena  = 1'b1;
                porta_d.wea  = 1'b1;
                porta_d.addr = addr_d;
                porta_d.din  = ~data_d;
            end
            COLLIDE: begin
                porta_d.ena  = 1'b1;
                porta_d.wea  = 1'b1;
                porta_d.addr = addr_q;
                porta_d.din  = data_q;
                portb_d.enb  = 1'b1;
                portb_d.addr = addr_q;
            end
            CLEAN_RD: begin
                portb_d.enb  = 1'b1;
                portb_d.addr = addr_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gen_en_q    <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            rsp_write_q <= '0;
            rsp_clean_q <= '0;
            available_q <= 1'b0;
            porta_q     <= '0;
            portb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gen_en_q    <= bus_io.gen_enable;
            data_q      <= data_d;
            addr_q      <= addr_d;
            rsp_write_q <= rsp_write_d;
            rsp_clean_q <= rsp_clean_d;
            available_q <= available_d;
            porta_q     <= porta_d;
            portb_q     <= portb_d;
        end
    end

    assign bus_io.available  = available_q;
    assign bus_io.rsp_write  = rsp_write_q;
    assign bus_io.rsp_clean  = rsp_clean_q;
    assign bus_io.bram_ena   = porta_q.ena;
    assign bus_io.bram_wea   = porta_q.wea;
    assign bus_io.bram_addra = porta_q.addr;
    assign bus_io.bram_dina  = porta_q.din;
    assign bus_io.bram_enb   = portb_q.enb;
    assign bus_io.bram_addrb = portb_q.addr;

endmodule

// File: tb/tb_rwc_responder.sv
// tb_rwc_responder: directed bench for rwc_responder with a behavioural dual-port BRAM.
// Latency: the BRAM model returns port-B data two edges after enb, matching READ_LATENCY=2.
// Backpressure: the bench drives gen_enable as the controller and releases it after each run.
module tb_rwc_responder;

    logic clk;
    logic rst;

    rwc_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    rwc_responder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (10),
        .SETTLE_CYCLES(4),
        .READ_LATENCY (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM collision behaviour: 0 read-first, 1 write-first, 2 collision read returns din ^ 0xF0.
    int          bram_mode;
    logic [31:0] mem [1024];
    logic [31:0] rd_p1;

    always @(posedge clk) begin
        if (bus.bram_ena && bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dina;
        if (bus.bram_enb) begin
            if (bus.bram_ena && bus.bram_wea && bus.bram_addra == bus.bram_addrb) begin
                case (bram_mode)
                    0:       rd_p1 <= mem[bus.bram_addrb];
                    1:       rd_p1 <= bus.bram_dina;
                    default: rd_p1 <= bus.bram_dina ^ 32'h0000_00F0;
                endcase
            end else begin
                rd_p1 <= mem[bus.bram_addrb];
            end
        end
        bus.bram_doutb <= rd_p1;
    end

    // Port activity monitor. Tests snapshot these counters and compare the deltas.
    logic [31:0] wr_log [$];
    int          both_cnt;
    int          addr_bad;
    logic [9:0]  exp_addr;

    initial begin
        both_cnt = 0;
        addr_bad = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.bram_ena && bus.bram_wea) wr_log.push_back(bus.bram_dina);
            if (bus.bram_ena && bus.bram_wea && bus.bram_enb && bus.bram_addra == bus.bram_addrb)
                both_cnt++;
            if (bus.bram_ena && bus.bram_addra != exp_addr) addr_bad++;
            if (bus.bram_enb && bus.bram_addrb != exp_addr) addr_bad++;
        end
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise gen_enable with the given challenge and count edges after the start edge until
    // available is seen. drop_after>0 releases gen_enable after that many edges. lat=-1 on timeout.
    task automatic do_run(input logic [31:0] d, input logic [31:0] a, input int drop_after,
                          output int lat);
        @(posedge clk); #1;
        bus.cha_data   = d;
        bus.cha_addr   = a;
        exp_addr       = a[9:0];
        bus.gen_enable = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == drop_after) bus.gen_enable = 1'b0;
            if (bus.available) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_and_check(input string tag);
        bus.gen_enable = 1'b0;
        @(posedge clk); #1;
        chk(tag, 32'(bus.available), 32'h0);
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_avail"},   32'(bus.available), 32'h0);
        chk({pfx, "_rspw"},    bus.rsp_write, 32'h0);
        chk({pfx, "_rspc"},    bus.rsp_clean, 32'h0);
        chk({pfx, "_enables"}, 32'({bus.bram_ena, bus.bram_wea, bus.bram_enb}), 32'h0);
        chk({pfx, "_addra"},   32'(bus.bram_addra), 32'h0);
        chk({pfx, "_addrb"},   32'(bus.bram_addrb), 32'h0);
        chk({pfx, "_dina"},    bus.bram_dina, 32'h0);
    endtask

    initial begin
        int lat;
        int wbase;
        int bbase;
        int abase;
        int acnt;
        bit found;

        n_tests        = 0;
        n_fail         = 0;
        bram_mode      = 0;
        exp_addr       = '0;
        rst            = 1'b1;
        bus.gen_enable = 1'b0;
        bus.cha_data   = '0;
        bus.cha_addr   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Nominal, read-first: preclear leaves 0, the collision read sees the old 0
        bram_mode = 0;
        wbase = wr_log.size();
        bbase = both_cnt;
        do_run(32'hFFFF_FFFF, 32'h0, -1, lat);
        chk("nom_latency", 32'(lat), 32'd11);
        chk("nom_rsp_write", bus.rsp_write, 32'h0000_0000);
        chk("nom_rsp_clean", bus.rsp_clean, 32'hFFFF_FFFF);
        chk("nom_write_count", 32'(wr_log.size() - wbase), 32'd2);
        if (wr_log.size() >= wbase + 2) begin
            chk("nom_preclear_din", wr_log[wbase], 32'h0000_0000);
            chk("nom_collide_din", wr_log[wbase + 1], 32'hFFFF_FFFF);
        end
        chk("nom_collide_overlap", 32'(both_cnt - bbase), 32'd1);
        release_and_check("nom_avail_drop");
        chk("nom_rsp_clean_hold", bus.rsp_clean, 32'hFFFF_FFFF);

        // Write-first BRAM at the top address
        bram_mode = 1;
        do_run(32'hA5A5_5A5A, 32'h0000_03FF, -1, lat);
        chk("wf_latency", 32'(lat), 32'd11);
        chk("wf_rsp_write", bus.rsp_write, 32'hA5A5_5A5A);
        chk("wf_rsp_clean", bus.rsp_clean, 32'hA5A5_5A5A);
        release_and_check("wf_avail_drop");

        // Collision-corrupting BRAM
        bram_mode = 2;
        do_run(32'hFFFF_FFFF, 32'h0, -1, lat);
        chk("cc_rsp_write", bus.rsp_write, 32'hFFFF_FF0F);
        chk("cc_rsp_clean", bus.rsp_clean, 32'hFFFF_FFFF);
        release_and_check("cc_avail_drop");

        // gen_enable dropped 3 cycles after start: the run completes with a 1-cycle available pulse
        bram_mode = 0;
        wbase = wr_log.size();
        do_run(32'h1234_5678, 32'h0000_0020, 3, lat);
        chk("drop_latency", 32'(lat), 32'd11);
        chk("drop_rsp_write", bus.rsp_write, 32'hEDCB_A987);
        chk("drop_rsp_clean", bus.rsp_clean, 32'h1234_5678);
        @(posedge clk); #1;
        chk("drop_avail_pulse", 32'(bus.available), 32'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("drop_no_rerun", 32'(wr_log.size() - wbase), 32'd2);

        // gen_enable held high for 40 cycles: exactly one run, available from edge 11 to edge 39
        wbase = wr_log.size();
        do_run(32'h0F0F_0F0F, 32'h0000_0100, -1, lat);
        chk("hold_latency", 32'(lat), 32'd11);
        acnt = (lat > 0) ? 1 : 0;
        for (int k = 12; k <= 39; k++) begin
            @(posedge clk); #1;
            if (bus.available) acnt++;
        end
        chk("hold_avail_cycles", 32'(acnt), 32'd29);
        chk("hold_rsp_write", bus.rsp_write, 32'hF0F0_F0F0);
        chk("hold_rsp_clean", bus.rsp_clean, 32'h0F0F_0F0F);
        release_and_check("hold_avail_drop");
        repeat (5) @(posedge clk);
        #1;
        chk("hold_single_run", 32'(wr_log.size() - wbase), 32'd2);

        // Reset during COLLIDE, then a clean nominal run
        @(posedge clk); #1;
        bus.cha_data   = 32'hFFFF_FFFF;
        bus.cha_addr   = 32'h0000_0055;
        exp_addr       = 10'h055;
        bus.gen_enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.bram_ena && bus.bram_enb) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstc_reached_collide", 32'(found), 32'h1);
        rst = 1'b1;
        bus.gen_enable = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("rstc");
        rst = 1'b0;
        do_run(32'hFFFF_FFFF, 32'h0000_0055, -1, lat);
        chk("rstc_latency", 32'(lat), 32'd11);
        chk("rstc_rsp_write", bus.rsp_write, 32'h0000_0000);
        chk("rstc_rsp_clean", bus.rsp_clean, 32'hFFFF_FFFF);
        release_and_check("rstc_avail_drop");

        // Upper challenge-address bits are ignored
        abase = addr_bad;
        do_run(32'h0000_1234, 32'h0000_0405, -1, lat);
        chk("addr_latency", 32'(lat), 32'd11);
        chk("addr_run_bad_cycles", 32'(addr_bad - abase), 32'd0);
        chk("addr_addra", 32'(bus.bram_addra), 32'h0000_0005);
        chk("addr_addrb", 32'(bus.bram_addrb), 32'h0000_0005);
        chk("addr_rsp_clean", bus.rsp_clean, 32'h0000_1234);
        release_and_check("addr_avail_drop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
